mc_sequencer: RTL
=================

// Module: mc_sequencer
// PURPOSE
//  Multi-cycle control sequencer for the next-generation SCC core. Replaces single-cycle timing
//  with an FSM (FETCH/DECODE/EXECUTE/MEM/WB) that owns PC and IR.
//  Handshakes with instruction and data memory over req/ack, so memory may take wait states.
//  Drives per-phase strobes to ID, RegFile and EX. Sits between top level, memory and datapath.
// PARAMETERS
//  ADDR_W      32  PC and branch-target width
//  DATA_W      32  instruction word width (IR)
//  PC_STEP     4   PC increment per sequential instruction
//  RESET_PC    0   PC value loaded at reset
//  MEM_TIMEOUT 15  max wait cycles per memory request before ERROR; 0 disables timeout
// PORTS
//  clk            in   1       main clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  run            in   1       1 = execute instructions; sampled at instruction boundaries
//  imem_req       out  1       instruction fetch request
//  imem_addr      out  ADDR_W  fetch address (= pc)
//  imem_ack       in   1       fetch data valid this cycle
//  imem_rdata     in   DATA_W  fetched instruction
//  ir             out  DATA_W  instruction register, feeds ID
//  dec_is_halt    in   1       ID: halt instruction
//  dec_is_branch  in   1       ID: branch instruction
//  dec_is_mem     in   1       ID: load/store
//  dec_is_store   in   1       ID: store (valid only with dec_is_mem)
//  dec_wb         in   1       ID: writes a register
//  branch_taken   in   1       EX: condition true (valid in EXECUTE)
//  branch_target  in   ADDR_W  EX: target address (valid in EXECUTE)
//  flags_we       out  1       EX flag update strobe
//  dmem_req       out  1       data memory request
//  dmem_we        out  1       1 = write, 0 = read (valid with dmem_req)
//  dmem_ack       in   1       data access complete this cycle
//  rf_we          out  1       RegFile write strobe
//  pc             out  ADDR_W  program counter
//  state          out  3       current FSM state code
//  retire         out  1       1-cycle pulse when an instruction completes
//  halted         out  1       core halted (sticky)
//  err            out  1       memory timeout error (sticky)
//  cycle_cnt      out  32      active-cycle counter (see CONFIGURATION)
//  instret_cnt    out  32      retired-instruction counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, pc=RESET_PC, ir=0, all strobes/req=0, halted=0, err=0,
//   counters=0. Mid-operation reset drops any outstanding request immediately.
//  States: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WB=5 HALT=6 ERROR=7.
//  IDLE: run=1 -> FETCH.
//  FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir<=imem_rdata -> DECODE. Same-cycle ack OK.
//  DECODE: 1 cycle. dec_is_halt -> HALT, else -> EXECUTE.
//  EXECUTE: flags_we=1 for 1 cycle. pc<=branch_target if dec_is_branch&branch_taken, else
//   pc<=pc+PC_STEP, modulo 2^ADDR_W (wraps). Next: dec_is_mem -> MEM; else dec_wb -> WB;
//   else retire -> FETCH if run else IDLE.
//  MEM: dmem_req=1, dmem_we=dec_is_store, held until dmem_ack. On ack: store -> retire,
//   FETCH/IDLE per run; load -> WB.
//  WB: rf_we=1 for 1 cycle, retire=1 -> FETCH if run else IDLE.
//  HALT: halted=1, no requests; exit only by reset. ERROR: err=1, no requests; exit by reset.
//  dec_* inputs are combinational from ir and stay stable DECODE..completion.
//  retire is registered with the state transition that completes the instruction.
//  Timeout: counter cleared on entry to FETCH/MEM. Increments each cycle req=1 and ack=0.
//   Counter reaching MEM_TIMEOUT -> ERROR next cycle. Ack in that same cycle wins (no error).
//  run=0 mid-instruction: instruction completes, then IDLE; pc holds next address.
//  Zero-wait CPI: branch/ALU-no-WB 3, ALU+WB 4, store 4, load 5 (FETCH..final state).
// CONFIGURATION
//  SCC_PERF_CNT_EN defined: cycle_cnt += 1 each cycle state not in {IDLE,HALT,ERROR};
//   instret_cnt += 1 on each retire. Both wrap at 2^32 and reset to 0.
//  Not defined: counter logic omitted, cycle_cnt and instret_cnt driven constant 0.
// TESTING
//  ALU+WB instr, zero-wait mem, run=1 -> states 1,2,3,5. rf_we pulse in WB.
//   retire pulse, then pc=4.
//  Load, dmem_ack after 3 waits -> dmem_req high 4 cycles, dmem_we=0, then WB, pc=4.
//  Taken branch at pc=0x10, target 0x40 -> pc=0x40 after EXECUTE, no rf_we, next fetch 0x40.
//  imem_ack never asserted, MEM_TIMEOUT=15 -> ERROR after 15 wait cycles, err=1, imem_req=0.
//  Ack on the 15th wait cycle -> DECODE, err stays 0.
//  pc=0xFFFFFFFC, non-branch -> pc wraps to 0x0. Halt instruction -> halted=1, no imem_req.
//  run=0 while in MEM -> store completes, retire, IDLE. Reset in FETCH -> imem_req=0, pc=0.
//   With SCC_PERF_CNT_EN: 3 ALU+WB instrs -> instret_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer -- multi-cycle control sequencer for the SCC core.
//
// Owns PC and IR and steps every instruction through FETCH / DECODE /
// EXECUTE / MEM / WB. Instruction and data memory use req/ack handshakes,
// so either memory may insert wait states. A per-request timeout sends
// the core to a sticky ERROR state.
//
// Optional feature macro: SCC_PERF_CNT_EN
//   defined     -> cycle_cnt / instret_cnt are live performance counters
//   not defined -> both counters are tied to zero
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   run                 run enable, sampled at instruction boundaries
//   imem_req/addr/ack/rdata
//                       instruction fetch handshake (addr = pc)
//   ir                  instruction register, feeds the decoder
//   dec_*               decoder flags (combinational from ir)
//   branch_taken/target branch resolution from EX
//   flags_we            EX flag update strobe (EXECUTE)
//   dmem_req/we/ack     data memory handshake
//   rf_we               register file write strobe (WB)
//   pc, state           program counter, FSM state code
//   retire              1-cycle pulse per completed instruction
//   halted, err         sticky halt / memory-timeout indications
//   cycle_cnt, instret_cnt
//                       performance counters
module mc_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  input  logic              dec_is_halt,
  input  logic              dec_is_branch,
  input  logic              dec_is_mem,
  input  logic              dec_is_store,
  input  logic              dec_wb,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              flags_we,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              retire,
  output logic              halted,
  output logic              err,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Value of the wait counter during the last permitted wait cycle; a
  // missing ack in that cycle is what triggers the timeout.
  localparam logic [CNT_W-1:0] TO_LAST =
    (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);
  localparam logic TO_EN = (MEM_TIMEOUT != 0);

  state_t            cur_state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              retire_q;

  logic              ir_load;
  logic              pc_load;
  logic              complete;
  logic              wait_inc;
  logic              wait_clr;
  logic              timeout_hit;
  logic [ADDR_W-1:0] pc_next;

  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);
  assign pc_next     = (dec_is_branch && branch_taken) ? branch_target
                                                       : pc_q + ADDR_W'(PC_STEP);
  // Entering a memory-request state restarts its timeout window.
  assign wait_clr    = (nxt_state != cur_state) &&
                       ((nxt_state == S_FETCH) || (nxt_state == S_MEM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_cnt  <= '0;
      retire_q  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      retire_q  <= complete;
      if (ir_load) ir_q <= imem_rdata;
      if (pc_load) pc_q <= pc_next;
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    flags_we  = 1'b0;
    rf_we     = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    complete  = 1'b0;
    wait_inc  = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (run) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // An ack in the final wait cycle still beats the timeout.
        if (imem_ack) begin
          ir_load   = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout_hit) begin
          nxt_state = S_ERROR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        nxt_state = dec_is_halt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        flags_we = 1'b1;
        pc_load  = 1'b1;
        if (dec_is_mem) begin
          nxt_state = S_MEM;
        end else if (dec_wb) begin
          nxt_state = S_WB;
        end else begin
          complete  = 1'b1;
          nxt_state = run ? S_FETCH : S_IDLE;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        if (dmem_ack) begin
          if (dec_is_store) begin
            complete  = 1'b1;
            nxt_state = run ? S_FETCH : S_IDLE;
          end else begin
            nxt_state = S_WB;
          end
        end else if (timeout_hit) begin
          nxt_state = S_ERROR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        complete  = 1'b1;
        nxt_state = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  nxt_state = S_HALT;
      S_ERROR: nxt_state = S_ERROR;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = cur_state;
  assign retire    = retire_q;
  assign halted    = (cur_state == S_HALT);
  assign err       = (cur_state == S_ERROR);

`ifdef SCC_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;
  logic        active;

  assign active = (cur_state != S_IDLE) && (cur_state != S_HALT) &&
                  (cur_state != S_ERROR);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (active)   cycle_q   <= cycle_q + 32'd1;
      if (retire_q) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
